// File: rtl/packer.sv
// Byte-to-word packer: gathers COUNT input bytes (or fewer when ilast ends a packet)
// into one output word with a per-lane keep mask, using a valid/ready handshake on both sides.
module packer #(
    parameter int COUNT = 2
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [7:0]           idata,
    input  logic                 ivalid,
    input  logic                 ilast,
    output logic                 iready,
    output logic [8*COUNT-1:0]   odata,
    output logic [COUNT-1:0]     okeep,
    output logic                 olast,
    output logic                 ovalid,
    input  logic                 oready
);
    localparam int IW = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [IW-1:0] LAST_LANE = IW'(COUNT - 1);

    logic [IW-1:0]            r_idx;
    logic [8*(COUNT-1)-1:0]   r_acc;
    logic [8*COUNT-1:0]       r_odata;
    logic [COUNT-1:0]         r_okeep;
    logic                     r_olast;
    logic                     r_ovalid;

    logic                     w_accept;
    logic                     w_complete;
    logic [8*COUNT-1:0]       w_word;
    logic [COUNT-1:0]         w_keep;
    logic [8*(COUNT-1)-1:0]   w_acc_next;

    // The output register is free when empty or being drained this cycle.
    assign iready     = !r_ovalid || oready;
    assign w_accept   = ivalid && iready;
    assign w_complete = w_accept && (ilast || (r_idx == LAST_LANE));

    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int k = 0; k < COUNT - 1; k++) begin
            if (int'(r_idx) > k) begin
                w_word[8*k +: 8] = r_acc[8*k +: 8];
            end
        end
        for (int k = 0; k < COUNT; k++) begin
            if (int'(r_idx) == k) begin
                w_word[8*k +: 8] = idata;
            end
            w_keep[k] = (int'(r_idx) >= k);
        end
    end

    always_comb begin
        w_acc_next = r_acc;
        if (w_complete) begin
            w_acc_next = '0;
        end else if (w_accept) begin
            for (int k = 0; k < COUNT - 1; k++) begin
                if (int'(r_idx) == k) begin
                    w_acc_next[8*k +: 8] = idata;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_idx    <= '0;
            r_acc    <= '0;
            r_odata  <= '0;
            r_okeep  <= '0;
            r_olast  <= 1'b0;
            r_ovalid <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            if (w_complete) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + 1'b1;
            end
            // A completing byte reloads the word even while the old one drains: no bubble.
            if (w_complete) begin
                r_odata  <= w_word;
                r_okeep  <= w_keep;
                r_olast  <= ilast;
                r_ovalid <= 1'b1;
            end else if (r_ovalid && oready) begin
                r_ovalid <= 1'b0;
            end
        end
    end

    assign odata  = r_odata;
    assign okeep  = r_okeep;
    assign olast  = r_olast;
    assign ovalid = r_ovalid;
endmodule
